seg_pipe_adder: RTL and testbench

Parametrised, segmented, pipelined add/subtract unit; successor to the full/half-adder block. The WIDTH-bit operation is split into SEG-bit slices, one slice per pipeline stage, with the carry registered between stages. Throughput is one operation per cycle, with valid/ready flow control and a signed-overflow flag. It sits in the datapath wherever a wide add/sub must close timing at full clock rate.

---
 rtl/seg_pipe_adder.sv | 123 ++++++++++++
 tb/tb_seg_pipe_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder: WIDTH-bit add/sub split into SEG-bit slices, one slice per
// pipeline stage, carry registered between stages, valid/ready flow control.
// Ports: clk, rst (sync, active-low), in_valid/in_ready, a, b, cin, sub,
//        out_valid/out_ready, sum, cout (raw carry, 1 = no borrow), ovf.
// Option: define SEG_PIPE_ADDER_SATURATE_EN to clamp sum on signed overflow.
module seg_pipe_adder #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / SEG;
  localparam int NR = (N > 1) ? N - 1 : 1;

  logic             w_en;
  logic [WIDTH-1:0] w_a   [N];
  logic [WIDTH-1:0] w_b   [N];
  logic [WIDTH-1:0] w_s   [N];
  logic [WIDTH-1:0] w_sn  [N];
  logic             w_c   [N];
  logic             w_v   [N];
  logic [SEG:0]     w_add [N];

  logic [WIDTH-1:0] r_a [NR];
  logic [WIDTH-1:0] r_b [NR];
  logic [WIDTH-1:0] r_s [NR];
  logic             r_c [NR];
  logic             r_v [NR];

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_sa;
  logic             w_sb;
  logic             w_ovf;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_sum;

  // One global enable: a stalled output freezes every stage.
  assign w_en     = !(r_out_valid && !out_ready);
  assign in_ready = w_en;

  // Stage inputs: stage 0 from ports (b and cin inverted for subtract),
  // later stages from the previous stage registers.
  always_comb begin
    w_a[0] = a;
    w_b[0] = sub ? ~b : b;
    w_c[0] = sub ? ~cin : cin;
    w_s[0] = '0;
    w_v[0] = in_valid;
    for (int k = 1; k < N; k++) begin
      w_a[k] = r_a[k-1];
      w_b[k] = r_b[k-1];
      w_c[k] = r_c[k-1];
      w_s[k] = r_s[k-1];
      w_v[k] = r_v[k-1];
    end
    for (int k = 0; k < N; k++) begin
      w_add[k] = {1'b0, w_a[k][k*SEG +: SEG]}
               + {1'b0, w_b[k][k*SEG +: SEG]}
               + (SEG+1)'(w_c[k]);
      w_sn[k] = w_s[k];
      w_sn[k][k*SEG +: SEG] = w_add[k][SEG-1:0];
    end
  end

  // Top slices of a and effective b are still original in the last stage.
  assign w_raw = w_sn[N-1];
  assign w_sa  = w_a[N-1][WIDTH-1];
  assign w_sb  = w_b[N-1][WIDTH-1];
  assign w_ovf = (w_sa == w_sb) && (w_raw[WIDTH-1] != w_sa);

`ifdef SEG_PIPE_ADDER_SATURATE_EN
  assign w_sum = !w_ovf ? w_raw
               : w_sa   ? {1'b1, {(WIDTH-1){1'b0}}}
               :          {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_sum = w_raw;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NR; k++) r_v[k] <= 1'b0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_en) begin
      for (int k = 0; k < N - 1; k++) begin
        r_v[k] <= w_v[k];
        r_a[k] <= w_a[k];
        r_b[k] <= w_b[k];
        r_c[k] <= w_add[k][SEG];
        r_s[k] <= w_sn[k];
      end
      r_out_valid <= w_v[N-1];
      r_sum       <= w_sum;
      r_cout      <= w_add[N-1][SEG];
      r_ovf       <= w_ovf;
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_seg_pipe_adder.sv
// tb_seg_pipe_adder: directed vector table, random stream with backpressure
// against an arithmetic reference model, and reset-while-in-flight checks.
module tb_seg_pipe_adder;

  localparam int W = 8;
  localparam int S = 4;
  localparam int N = W / S;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  seg_pipe_adder #(.WIDTH(W), .SEG(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  vec_t tbl [8];
  logic [9:0] q [$];

`ifdef SEG_PIPE_ADDER_SATURATE_EN
  localparam logic [7:0] E1 = 8'h7F;
  localparam logic [7:0] E3 = 8'h80;
  localparam logic [7:0] E5 = 8'h80;
`else
  localparam logic [7:0] E1 = 8'h80;
  localparam logic [7:0] E3 = 8'h7F;
  localparam logic [7:0] E5 = 8'h00;
`endif

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
  function automatic logic [9:0] model(input logic [7:0] ma,
                                       input logic [7:0] mb,
                                       input logic mc, input logic ms);
    int   u;
    int   sa;
    int   sb;
    int   s;
    logic o;
    logic [7:0] r;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (ms) begin
      u = int'(ma) + (255 - int'(mb)) + (1 - int'(mc));
      s = sa - sb - int'(mc);
    end else begin
      u = int'(ma) + int'(mb) + int'(mc);
      s = sa + sb + int'(mc);
    end
    o = (s > 127) || (s < -128);
    r = u[7:0];
`ifdef SEG_PIPE_ADDER_SATURATE_EN
    if (o) r = (s > 127) ? 8'h7F : 8'h80;
`endif
    return {o, u[8], r};
  endfunction

  task automatic apply_one(input vec_t v, input string tag);
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < N; i++) begin
      chk({tag, "_early"}, out_valid, 0);
      @(negedge clk);
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, sum, v.es);
    chk({tag, "_cout"}, cout, v.ec);
    chk({tag, "_ovf"}, ovf, v.eo);
  endtask

  initial begin
    int   sent;
    int   rcvd;
    int   cyc;
    logic acc_prev;
    logic stall_prev;
    logic [9:0] prev_out;
    logic [9:0] exp;

    tbl[0] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, E1,    1'b0, 1'b1};
    tbl[2] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, E3,    1'b1, 1'b1};
    tbl[4] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 1'b0, E5,    1'b1, 1'b1};
    tbl[6] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[7] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

    // Reset held two cycles with an operation offered.
    rst = 1'b0; in_valid = 1'b1;
    a = 8'hFF; b = 8'h01; cin = 1'b1; sub = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);

    for (int i = 0; i < 8; i++) apply_one(tbl[i], $sformatf("vec%0d", i));

    // Random stream with backpressure.
    sent = 0; rcvd = 0; cyc = 0;
    acc_prev = 1'b0; stall_prev = 1'b0; prev_out = '0;
    in_valid = 1'b0;
    while (rcvd < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (stall_prev) chk("hold", {ovf, cout, sum}, prev_out);
      if (!in_valid || acc_prev) begin
        if (sent < 1000) begin
          a = W'($urandom); b = W'($urandom);
          cin = 1'($urandom); sub = 1'($urandom);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 99) >= 30);
      #1;
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        chk("no_spurious", q.size() != 0, 1);
        if (q.size() != 0) begin
          exp = q.pop_front();
          chk($sformatf("stream%0d", rcvd), {ovf, cout, sum}, exp);
        end
        rcvd++;
      end
      acc_prev = in_valid && in_ready;
      if (acc_prev) begin
        q.push_back(model(a, b, cin, sub));
        sent++;
      end
      stall_prev = out_valid && !out_ready;
      prev_out = {ovf, cout, sum};
    end
    in_valid = 1'b0;
    chk("stream_rcvd", rcvd, 1000);
    chk("stream_sent", sent, 1000);
    chk("queue_empty", q.size(), 0);

    // Two operations in flight, output stalled, then reset.
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    a = 8'h33; b = 8'h44;
    @(negedge clk);
    chk("flight_stalled", in_ready, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("flush_valid", out_valid, 0);
      @(negedge clk);
    end
    apply_one(tbl[0], "after_flush");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
